// File: rtl/sliding_window_gen_pkg.sv
// Shared definitions for the sliding-window producer and the convolve engine:
// pixel width, window sizing helpers and the producer FSM encoding.
package sliding_window_gen_pkg;

    localparam int PIXEL_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PRESENT,
        WAIT_SHIFT,
        LOAD_ROW,
        DONE
    } state_t;

    // Width in bits of one flattened filter_size x filter_size window.
    function automatic int window_bits(input int filter_size);
        return filter_size * filter_size * PIXEL_W;
    endfunction

    // Number of valid window positions along one image dimension.
    function automatic int out_dim(input int image_dim, input int filter_size);
        return image_dim - filter_size + 1;
    endfunction

    function automatic int index_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sliding_window_gen_row_buffer.sv
// Circular FILTER_SIZE x IMAGE_WIDTH byte store with one write port and a
// combinational read of the FILTER_SIZE x FILTER_SIZE patch starting at slot rd_top.
module window_row_buffer
    import sliding_window_gen_pkg::*;
#(
    parameter int IMAGE_WIDTH = 5,
    parameter int FILTER_SIZE = 3,
    parameter int SLOT_W      = index_w(FILTER_SIZE),
    parameter int COL_W       = index_w(IMAGE_WIDTH)
) (
    input  logic                                  clk,
    input  logic                                  wr_en,
    input  logic [SLOT_W-1:0]                     wr_slot,
    input  logic [COL_W-1:0]                      wr_col,
    input  logic [PIXEL_W-1:0]                    wr_data,
    input  logic [SLOT_W-1:0]                     rd_top,
    input  logic [COL_W-1:0]                      rd_col,
    output logic [window_bits(FILTER_SIZE)-1:0]   patch
);

    localparam logic [SLOT_W:0] FS_EXT = (SLOT_W+1)'(FILTER_SIZE);

    logic [PIXEL_W-1:0] mem [FILTER_SIZE][IMAGE_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_data;
        end
    end

    // Row i of the window lives in slot (rd_top + i) mod FILTER_SIZE; the sum
    // never reaches 2*FILTER_SIZE, so a single conditional subtract suffices.
    for (genvar i = 0; i < FILTER_SIZE; i++) begin : g_row
        logic [SLOT_W:0]   sum;
        logic [SLOT_W-1:0] slot;

        assign sum  = {1'b0, rd_top} + (SLOT_W+1)'(i);
        assign slot = (sum >= FS_EXT) ? SLOT_W'(sum - FS_EXT) : SLOT_W'(sum);

        for (genvar j = 0; j < FILTER_SIZE; j++) begin : g_col
            logic [COL_W-1:0] col;

            assign col = rd_col + COL_W'(j);
            assign patch[(i*FILTER_SIZE+j)*PIXEL_W +: PIXEL_W] = mem[slot][col];
        end
    end

endmodule

// File: rtl/sliding_window_gen.sv
// Producer side of the window/convolve handshake: buffers FILTER_SIZE image rows
// and hands one flattened window at a time to the engine, advancing on shift_buffer.
module sliding_window_gen
    import sliding_window_gen_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int FILTER_SIZE  = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [PIXEL_W-1:0]                   pixel_in,
    input  logic                                 pixel_valid,
    output logic                                 pixel_ready,
    output logic [window_bits(FILTER_SIZE)-1:0]  window_out,
    output logic                                 window_valid,
    input  logic                                 shift_buffer,
    output logic [7:0]                           win_row,
    output logic [7:0]                           win_col,
    output logic                                 busy,
    output logic                                 frame_done
);

    localparam int OUT_W  = out_dim(IMAGE_WIDTH, FILTER_SIZE);
    localparam int OUT_H  = out_dim(IMAGE_HEIGHT, FILTER_SIZE);
    localparam int SLOT_W = index_w(FILTER_SIZE);
    localparam int COL_W  = index_w(IMAGE_WIDTH);
    localparam int WIN_W  = window_bits(FILTER_SIZE);

    localparam logic [SLOT_W-1:0] SLOT_LAST    = SLOT_W'(FILTER_SIZE - 1);
    localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [7:0]        WIN_COL_LAST = 8'(OUT_W - 1);
    localparam logic [7:0]        WIN_ROW_LAST = 8'(OUT_H - 1);

    state_t             state;
    state_t             next_state;
    logic [SLOT_W-1:0]  fill_slot;
    logic [SLOT_W-1:0]  top;
    logic [COL_W-1:0]   pix_col;
    logic [SLOT_W-1:0]  wr_slot;
    logic [WIN_W-1:0]   patch;
    logic               loading;
    logic               accept;
    logic               row_end;
    logic               more_cols;
    logic               more_rows;

    assign loading     = (state == FILL) || (state == LOAD_ROW);
    assign pixel_ready = loading;
    assign accept      = pixel_valid && loading;
    assign row_end     = (pix_col == COL_LAST);
    assign more_cols   = (win_col < WIN_COL_LAST);
    assign more_rows   = (win_row < WIN_ROW_LAST);

    // FILL writes slots in order; LOAD_ROW always replaces the oldest row.
    assign wr_slot = (state == FILL) ? fill_slot : top;

    window_row_buffer #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .FILTER_SIZE (FILTER_SIZE),
        .SLOT_W      (SLOT_W),
        .COL_W       (COL_W)
    ) u_row_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .wr_slot (wr_slot),
        .wr_col  (pix_col),
        .wr_data (pixel_in),
        .rd_top  (top),
        .rd_col  (COL_W'(win_col)),
        .patch   (patch)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (accept && row_end && (fill_slot == SLOT_LAST)) begin
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                busy       = 1'b1;
                next_state = WAIT_SHIFT;
            end
            WAIT_SHIFT: begin
                busy = 1'b1;
                if (shift_buffer) begin
                    if (more_cols) begin
                        next_state = PRESENT;
                    end else if (more_rows) begin
                        next_state = LOAD_ROW;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            LOAD_ROW: begin
                busy = 1'b1;
                if (accept && row_end) begin
                    next_state = PRESENT;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_slot    <= '0;
            top          <= '0;
            pix_col      <= '0;
            win_row      <= '0;
            win_col      <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        fill_slot <= '0;
                        top       <= '0;
                        pix_col   <= '0;
                        win_row   <= '0;
                        win_col   <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        pix_col <= row_end ? '0 : pix_col + 1'b1;
                        if (row_end) begin
                            fill_slot <= (fill_slot == SLOT_LAST) ? '0 : fill_slot + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    // Window is captured here so it stays frozen through WAIT_SHIFT.
                    window_out   <= patch;
                    window_valid <= 1'b1;
                end
                WAIT_SHIFT: begin
                    if (shift_buffer) begin
                        if (more_cols) begin
                            win_col <= win_col + 1'b1;
                        end else if (more_rows) begin
                            win_col <= '0;
                            win_row <= win_row + 1'b1;
                        end
                    end
                end
                LOAD_ROW: begin
                    if (accept) begin
                        pix_col <= row_end ? '0 : pix_col + 1'b1;
                        if (row_end) begin
                            top <= (top == SLOT_LAST) ? '0 : top + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
